// File: rtl/reload_timer_pkg.sv
// Shared definitions for reload_timer: state encoding, default widths and the
// start/terminal value helpers used by the counter datapath.
package reload_timer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int PSC_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Start value: counting up begins at 0, counting down begins at N.
  function automatic logic [31:0] start_val(input logic up, input logic [31:0] n);
    return up ? 32'd0 : n;
  endfunction

  // Terminal value: counting up ends at N, counting down ends at 0.
  function automatic logic [31:0] term_val(input logic up, input logic [31:0] n);
    return up ? n : 32'd0;
  endfunction

endpackage

// File: rtl/reload_timer_psc.sv
// Tick prescaler for reload_timer: asserts tick once every psc+1 enabled clocks.
// Only instantiated when RELOAD_TIMER_PSC_EN is defined.
module reload_timer_psc
  import reload_timer_pkg::*;
#(
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] r_cnt;

  assign tick = en && (r_cnt == psc);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + PSC_W'(1);
    end
  end

endmodule

// File: rtl/reload_timer.sv
// Parametrised up/down reload timer with one-shot mode and start/stop control.
// Define RELOAD_TIMER_PSC_EN to include the tick prescaler; otherwise every RUN clock ticks.
module reload_timer
  import reload_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] load,
  input  logic             up,
  input  logic             oneshot,
  input  logic [PSC_W-1:0] psc,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] w_n_nxt;
  logic             r_tc;
  logic             r_busy;
  logic             r_up;
  logic             r_oneshot;
  logic             w_count_wr;
  logic             w_start_acc;
  logic             w_up_nxt;
  logic             w_tc_nxt;
  logic             w_tick;
  logic             w_run;

  function automatic logic [WIDTH-1:0] s_of(input logic u, input logic [WIDTH-1:0] n);
    return WIDTH'(start_val(u, 32'(n)));
  endfunction

  function automatic logic [WIDTH-1:0] t_of(input logic u, input logic [WIDTH-1:0] n);
    return WIDTH'(term_val(u, 32'(n)));
  endfunction

  assign w_run       = (r_state == RUN);
  assign w_start_acc = start && !stop;
  assign w_up_nxt    = w_start_acc ? up : r_up;

`ifdef RELOAD_TIMER_PSC_EN
  logic [PSC_W-1:0] r_psc;

  always_ff @(posedge clk) begin
    if (w_start_acc) begin
      r_psc <= psc;
    end
  end

  reload_timer_psc #(.PSC_W(PSC_W)) u_psc (
    .clk   (clk),
    .reset (reset),
    .clear (w_start_acc),
    .en    (w_run),
    .psc   (r_psc),
    .tick  (w_tick)
  );
`else
  logic w_unused_psc;
  assign w_unused_psc = ^psc;
  assign w_tick       = 1'b1;
`endif

  // Next state and counter update; stop outranks start, start outranks a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_count_wr  = 1'b0;
    w_count_nxt = r_count;
    w_n_nxt     = r_n;
    if (stop) begin
      w_state_nxt = IDLE;
    end else if (start) begin
      w_state_nxt = RUN;
      w_n_nxt     = load;
      w_count_wr  = 1'b1;
      w_count_nxt = s_of(up, load);
    end else if (w_run && w_tick) begin
      if (r_count != t_of(r_up, r_n)) begin
        w_count_wr  = 1'b1;
        w_count_nxt = r_up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
      end else if (r_oneshot) begin
        w_state_nxt = DONE;
      end else begin
        // Reload picks up the current load value, so load edits apply per period.
        w_n_nxt     = load;
        w_count_wr  = 1'b1;
        w_count_nxt = s_of(r_up, load);
      end
    end
  end

  // tc marks only the edge that writes T, never the clocks count merely sits at T.
  assign w_tc_nxt = w_count_wr && (w_count_nxt == t_of(w_up_nxt, w_n_nxt));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_count_wr) begin
        r_count <= w_count_nxt;
      end
      r_tc   <= w_tc_nxt;
      r_busy <= (w_state_nxt == RUN);
    end
  end

  always_ff @(posedge clk) begin
    r_n <= w_n_nxt;
    if (w_start_acc) begin
      r_up      <= up;
      r_oneshot <= oneshot;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = r_busy;

endmodule

// File: tb/tb_reload_timer.sv
// Self-checking bench for reload_timer: vector table plus hand-written multi-cycle sequences.
module tb_reload_timer;

  localparam int W  = 8;
  localparam int PW = 8;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [W-1:0]  load;
  logic          up;
  logic          oneshot;
  logic [PW-1:0] psc;
  logic [W-1:0]  count;
  logic          tc;
  logic          busy;

  always #5 clk = ~clk;

  reload_timer #(.WIDTH(W), .PSC_W(PW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .load    (load),
    .up      (up),
    .oneshot (oneshot),
    .psc     (psc),
    .count   (count),
    .tc      (tc),
    .busy    (busy)
  );

  typedef struct {
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
  } exp_t;

  typedef struct {
    logic          rst;
    logic          st;
    logic          sp;
    logic [W-1:0]  ld;
    logic          u;
    logic          os;
    logic [PW-1:0] ps;
    logic [W-1:0]  ec;
    logic          etc;
    logic          eb;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];
  exp_t sb [$];
  int   tc_at [$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  int   pdiv;
  int   ph;

  function automatic vec_t mkv(input logic rst, input logic st, input logic sp,
                               input logic [W-1:0] ld, input logic u, input logic os,
                               input logic [W-1:0] ec, input logic etc, input logic eb);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.ld = ld; v.u = u; v.os = os;
    v.ps = '0; v.ec = ec; v.etc = etc; v.eb = eb;
    return v;
  endfunction

  task automatic chk_cycle(input logic [W-1:0] ec, input logic etc, input logic eb,
                           input string nm);
    exp_t e;
    e.count = ec; e.tc = etc; e.busy = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ncyc++;
    if (tc === 1'b1) tc_at.push_back(ncyc);
    e = sb.pop_front();
    checks++;
    if (count !== e.count || tc !== e.tc || busy !== e.busy) begin
      errors++;
      $display("FAIL %s @%0d: count=%0d tc=%0b busy=%0b, required count=%0d tc=%0b busy=%0b",
               nm, ncyc, count, tc, busy, e.count, e.tc, e.busy);
    end
  endtask

  task automatic chk_int(input int act, input int req, input string nm);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  initial begin
    tbl[0]  = mkv(H, L, L, 8'd0, L, L, 8'd0, L, L);
    tbl[1]  = mkv(L, L, L, 8'd0, L, L, 8'd0, L, L);
    tbl[2]  = mkv(L, H, H, 8'd9, L, L, 8'd0, L, L);
    tbl[3]  = mkv(L, L, L, 8'd9, L, L, 8'd0, L, L);
    tbl[4]  = mkv(L, H, L, 8'd0, L, L, 8'd0, H, H);
    tbl[5]  = mkv(L, L, L, 8'd0, L, L, 8'd0, H, H);
    tbl[6]  = mkv(L, L, L, 8'd0, L, L, 8'd0, H, H);
    tbl[7]  = mkv(L, L, L, 8'd0, L, L, 8'd0, H, H);
    tbl[8]  = mkv(L, L, H, 8'd0, L, L, 8'd0, L, L);
    tbl[9]  = mkv(L, H, L, 8'd3, H, H, 8'd0, L, H);
    tbl[10] = mkv(L, L, L, 8'd3, H, H, 8'd1, L, H);
    tbl[11] = mkv(L, L, L, 8'd3, H, H, 8'd2, L, H);
    tbl[12] = mkv(L, L, L, 8'd3, H, H, 8'd3, H, H);
    tbl[13] = mkv(L, L, L, 8'd3, H, H, 8'd3, L, L);
    tbl[14] = mkv(L, L, L, 8'd3, H, H, 8'd3, L, L);
    tbl[15] = mkv(L, L, H, 8'd3, H, H, 8'd3, L, L);
    tbl[16] = mkv(L, H, L, 8'd2, L, L, 8'd2, L, H);
    tbl[17] = mkv(L, L, L, 8'd2, L, L, 8'd1, L, H);
    tbl[18] = mkv(L, L, H, 8'd2, L, L, 8'd1, L, L);
    tbl[19] = mkv(L, H, L, 8'd0, H, H, 8'd0, H, H);
    tbl[20] = mkv(L, L, L, 8'd0, H, H, 8'd0, L, L);

    reset = H; start = L; stop = L; load = '0; up = L; oneshot = L; psc = '0;

    // Vector table: reset, start+stop, zero load, short one-shot, stop holds count.
    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; stop = tbl[i].sp; load = tbl[i].ld;
      up = tbl[i].u; oneshot = tbl[i].os; psc = tbl[i].ps;
      chk_cycle(tbl[i].ec, tbl[i].etc, tbl[i].eb, $sformatf("vec%0d", i));
    end
    start = L; stop = L;

    // Down-count auto-reload of 20, with load changed to 30 mid-period.
    reset = H; chk_cycle('0, L, L, "dn_reset");
    reset = L; load = 8'd20; up = L; oneshot = L; psc = '0; start = H;
    tc_at.delete();
    chk_cycle(8'd20, L, H, "dn_start");
    start = L;
    for (int k = 1; k <= 20; k++) chk_cycle(W'(20 - k), (k == 20), H, $sformatf("dn_p1 k%0d", k));
    chk_cycle(8'd20, L, H, "dn_reload1");
    for (int j = 1; j <= 20; j++) begin
      chk_cycle(W'(20 - j), (j == 20), H, $sformatf("dn_p2 j%0d", j));
      if (j == 8) load = 8'd30;
    end
    chk_cycle(8'd30, L, H, "dn_reload2");
    for (int j = 1; j <= 30; j++) chk_cycle(W'(30 - j), (j == 30), H, $sformatf("dn_p3 j%0d", j));
    chk_int(tc_at.size(), 3, "dn_tc_count");
    if (tc_at.size() >= 3) begin
      chk_int(tc_at[1] - tc_at[0], 21, "dn_tc_period_20");
      chk_int(tc_at[2] - tc_at[1], 31, "dn_tc_period_30");
    end

    // Prescaler psc=3, load=2, down.
`ifdef RELOAD_TIMER_PSC_EN
    pdiv = 4;
`else
    pdiv = 1;
`endif
    reset = H; chk_cycle('0, L, L, "psc_reset");
    reset = L; load = 8'd2; psc = 8'd3; up = L; oneshot = L; start = H;
    chk_cycle(8'd2, L, H, "psc_start");
    start = L;
    for (int k = 1; k <= 24; k++) begin
      ph = (k / pdiv) % 3;
      chk_cycle(W'(2 - ph), ((k % pdiv) == 0) && (ph == 2), H, $sformatf("psc k%0d", k));
    end
    stop = H;
    chk_cycle(W'(2 - ((24 / pdiv) % 3)), L, L, "psc_stop");
    stop = L; psc = '0;

    // Up one-shot to 5, then DONE holds 5 even if load changes.
    load = 8'd5; up = H; oneshot = H; start = H;
    chk_cycle(8'd0, L, H, "os_start");
    start = L;
    for (int k = 1; k <= 5; k++) chk_cycle(W'(k), (k == 5), H, $sformatf("os k%0d", k));
    load = 8'd9;
    for (int k = 6; k <= 9; k++) chk_cycle(8'd5, L, L, $sformatf("os_done k%0d", k));

    // Up auto-reload of 3 re-armed from DONE.
    load = 8'd3; up = H; oneshot = L; start = H;
    chk_cycle(8'd0, L, H, "up_start");
    start = L;
    for (int k = 1; k <= 8; k++) chk_cycle(W'(k % 4), ((k % 4) == 3), H, $sformatf("up k%0d", k));

    // Reset at count=7 with start asserted in the same cycle.
    reset = H; chk_cycle('0, L, L, "rst_pre");
    reset = L; load = 8'd10; up = L; oneshot = L; start = H;
    chk_cycle(8'd10, L, H, "rst_start");
    start = L;
    for (int k = 1; k <= 3; k++) chk_cycle(W'(10 - k), L, H, $sformatf("rst_run k%0d", k));
    reset = H; start = H;
    chk_cycle('0, L, L, "rst_mid");
    reset = L; start = L;
    chk_cycle('0, L, L, "rst_after1");
    chk_cycle('0, L, L, "rst_after2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
